// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- MEM stage of the five-stage pipeline.
//
// Sits between the EX/MEM and MEM/WB latches. Non-memory instructions pass
// straight through. Loads and stores run one request/acknowledge beat on the
// data bus while stallreq_o holds the pipeline. Stores get big-endian byte
// lane steering; loads get sign/zero extension of the selected lane.
//
// Ports
//   clk, rst                 pipeline clock, synchronous active-high reset
//   pc_i/rw_i/wreg_i/wdata_i/whilo_i/hi_i/lo_i   EX/MEM fields
//   pc_o/rw_o/wreg_o/wdata_o/whilo_o/hi_o/lo_o   to MEM/WB
//   aluop_i                  operation code (loads/stores decoded here)
//   mem_addr_i, reg2_i       effective address and store data
//   stall                    stall vector from ctrl, bit 4 = MEM hold
//   stallreq_o               stall request to ctrl
//   mem_ce_o/mem_we_o/mem_addr_o/mem_sel_o/mem_data_o   data bus request
//   mem_data_i, mem_ack_i    data bus response
//
// Optional build macro: MEM_UNALIGNED_EXC_EN
//   When defined, misaligned halfword/word accesses issue no bus cycle and
//   raise adel_o (load) or ades_o (store) for that cycle instead.
// ---------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [4:0]  rw_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  stall,
  output logic [31:0] pc_o,
  output logic [4:0]  rw_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
`ifdef MEM_UNALIGNED_EXC_EN
  output logic        adel_o,
  output logic        ades_o,
`endif
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_ce_q, mem_ce_d;
  logic [31:0] load_q, load_d;

  // Bus request fields, captured when a transaction starts and held in BUSY.
  logic        mem_we_q;
  logic [29:0] word_addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wr_data_q;
  logic [1:0]  off_q;

  logic is_load, is_store, is_mem, misaligned, start;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Big-endian lanes: byte offset 0 lives in bits [31:24] (sel bit 3).
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_LB, OP_LBU, OP_SB: s = 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: s = off[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         s = 4'b1111;
      default:              s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate the store operand across every lane; sel picks the live ones.
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      OP_SW:   r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      OP_LW:   r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
      default: ;
    endcase
  end
  assign is_mem = is_load | is_store;

`ifdef MEM_UNALIGNED_EXC_EN
  always_comb begin
    misaligned = 1'b0;
    case (aluop_i)
      OP_LH, OP_LHU, OP_SH: misaligned = mem_addr_i[0];
      OP_LW, OP_SW:         misaligned = |mem_addr_i[1:0];
      default: ;
    endcase
  end
`else
  // Low address bits below the access size are simply ignored.
  assign misaligned = 1'b0;
`endif

  assign start = (state_q == S_IDLE) && is_mem && !misaligned;

  always_comb begin
    state_d  = state_q;
    mem_ce_d = mem_ce_q;
    load_d   = load_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BUSY;
          mem_ce_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          state_d  = S_DONE;
          mem_ce_d = 1'b0;
          load_d   = load_ext(aluop_i, off_q, mem_data_i);
        end
      end
      S_DONE: begin
        // Never chain a new transaction from here; always pass through IDLE.
        if (!stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_ce_q <= 1'b0;
      load_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      mem_ce_q <= mem_ce_d;
      load_q   <= load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mem_we_q    <= is_store;
      word_addr_q <= mem_addr_i[31:2];
      sel_q       <= lane_sel(aluop_i, mem_addr_i[1:0]);
      wr_data_q   <= store_data(aluop_i, reg2_i);
      off_q       <= mem_addr_i[1:0];
    end
  end

  always_comb begin
    pc_o       = pc_i;
    rw_o       = rw_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    whilo_o    = whilo_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    stallreq_o = 1'b0;
`ifdef MEM_UNALIGNED_EXC_EN
    adel_o     = 1'b0;
    ades_o     = 1'b0;
`endif
    // Bus fields are only driven while a request is live.
    mem_ce_o   = mem_ce_q;
    mem_we_o   = mem_ce_q & mem_we_q;
    mem_addr_o = mem_ce_q ? {word_addr_q, 2'b00} : 32'd0;
    mem_sel_o  = mem_ce_q ? sel_q : 4'b0000;
    mem_data_o = (mem_ce_q && mem_we_q) ? wr_data_q : 32'd0;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          wreg_o = 1'b0;
          if (misaligned) begin
`ifdef MEM_UNALIGNED_EXC_EN
            adel_o = is_load;
            ades_o = is_store;
`endif
          end else begin
            stallreq_o = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        whilo_o    = 1'b0;
      end
      S_DONE: begin
        if (is_load) wdata_o = load_q;
      end
      default: ;
    endcase

    if (rst) begin
      pc_o       = 32'd0;
      rw_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      whilo_o    = 1'b0;
      hi_o       = 32'd0;
      lo_o       = 32'd0;
      stallreq_o = 1'b0;
      mem_ce_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = 32'd0;
      mem_sel_o  = 4'b0000;
      mem_data_o = 32'd0;
`ifdef MEM_UNALIGNED_EXC_EN
      adel_o     = 1'b0;
      ades_o     = 1'b0;
`endif
    end
  end

endmodule
